// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for a radix-2^2 SDF FFT pipeline: handshakes samples in,
// zero-pads partial frames, flushes the pipe and tags output bins.
// Ports: clk/rst (sync, active-high), start/flush requests,
// in_valid/in_ready sample handshake, fft_en/zero_in/ctrl_cnt datapath
// control, out_valid/out_first/out_last/out_index output tagging,
// busy/done session status.
module fft_seq_ctrl #(
  parameter int N_POINTS     = 16,
  parameter int PIPE_LATENCY = 15,
  localparam int LOG2N       = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fft_en,
  output logic             zero_in,
  output logic [LOG2N-1:0] ctrl_cnt,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic [LOG2N-1:0] out_index,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(4 * N_POINTS + 1);
  localparam logic [FW-1:0] LAT = FW'(PIPE_LATENCY);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD,
    FLUSH
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [LOG2N-1:0] ctrl_nx;
  logic [LOG2N-1:0] out_cnt;
  logic [LOG2N-1:0] out_nx;
  logic [FW-1:0]    fill_cnt;
  logic [FW-1:0]    fill_nx;
  logic [FW-1:0]    flush_cnt;
  logic [FW-1:0]    flush_nx;
  logic             done_nx;

  always_comb begin
    in_ready  = (state == RUN);
    zero_in   = (state == PAD) || (state == FLUSH);
    fft_en    = (in_ready && in_valid) || zero_in;
    out_valid = fft_en && (fill_cnt == LAT);
    out_first = out_valid && (out_cnt == '0);
    out_last  = out_valid && (out_cnt == LAST_IDX);
    busy      = (state != IDLE);
    for (int i = 0; i < LOG2N; i++) begin
      out_index[i] = out_cnt[LOG2N-1-i];
    end
  end

  always_comb begin
    state_nx = state;
    ctrl_nx  = fft_en ? ctrl_cnt + 1'b1 : ctrl_cnt;
    fill_nx  = (fft_en && fill_cnt != LAT) ? fill_cnt + 1'b1 : fill_cnt;
    out_nx   = out_valid ? out_cnt + 1'b1 : out_cnt;
    flush_nx = flush_cnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        // Decision uses post-step counts so a sample accepted together
        // with flush is part of the final frame.
        if (flush) begin
          if (ctrl_nx != '0) begin
            state_nx = PAD;
          end else if (fill_nx != '0) begin
            state_nx = FLUSH;
            flush_nx = LAT;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      PAD: begin
        if (ctrl_cnt == LAST_IDX) begin
          state_nx = FLUSH;
          flush_nx = LAT;
        end
      end
      FLUSH: begin
        flush_nx = flush_cnt - 1'b1;
        if (flush_cnt == FW'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          fill_nx  = '0;
          out_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ctrl_cnt  <= '0;
      fill_cnt  <= '0;
      out_cnt   <= '0;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      ctrl_cnt  <= ctrl_nx;
      fill_cnt  <= fill_nx;
      out_cnt   <= out_nx;
      flush_cnt <= flush_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Frame sequencer for the radix-2^2 single-path delay-feedback FFT pipeline. It sits between the sample source and the FFT datapath. It owns the pipeline advance enable and the LOG2N-bit stage control bus, accepts input samples over a valid/ready handshake, and zero-pads partial frames. It also tracks pipeline fill, flushes the pipeline after the last frame, and tags the emitted spectrum samples with valid, first/last and bit-reversed bin index.

## Interface
- N_POINTS, 16, FFT size; power of 4, minimum 16.
- PIPE_LATENCY, 15, number of pipeline advance steps from a sample entering to its result appearing at the FFT output; 1 to 4*N_POINTS.
- LOG2N (derived, not overridable), $clog2(N_POINTS).

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a session; honoured only in IDLE.
- flush  in  1  single-cycle request to end the session; honoured only in RUN.
- in_valid  in  1  source has a sample.
- in_ready  out  1  sequencer accepts a sample this cycle.
- fft_en  out  1  advance the pipeline one step this cycle.
- zero_in  out  1  datapath input mux selects 0+j0 instead of the source sample.
- ctrl_cnt  out  LOG2N  stage control bus: index of the sample entering this step.
- out_valid  out  1  FFT output is a real spectrum sample this step.
- out_first / out_last  out  1  out_valid and bin 0 / bin N_POINTS-1 of a frame.
- out_index  out  LOG2N  bin number of the current output, bit-reversed output order.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when FLUSH completes.

## Operation
- States: IDLE, RUN, PAD, FLUSH. Reset state is IDLE. On reset, ctrl_cnt, fill_cnt, out_cnt and the flush counter are 0, and every output is 0.
- Step definition: fft_en = (RUN & in_valid) | PAD | FLUSH. in_ready = RUN (combinational from state). zero_in = PAD | FLUSH.
- ctrl_cnt increments modulo N_POINTS on every step and holds otherwise.
- fill_cnt counts steps and saturates at PIPE_LATENCY.
- out_valid = fft_en & (fill_cnt == PIPE_LATENCY), using the pre-increment value of fill_cnt.
- out_cnt increments modulo N_POINTS on every out_valid.
  - out_index = bit-reverse(out_cnt).
  - out_first = out_valid & (out_cnt == 0).
  - out_last = out_valid & (out_cnt == N_POINTS-1).
- IDLE -> RUN on start.
- RUN behaviour on flush:
  - Evaluate flush against the ctrl_cnt value after this cycle's step, if any. A flush coinciding with an accepted sample counts that sample.
  - If that ctrl_cnt != 0, go to PAD.
  - Else, if fill_cnt (post-step) != 0, go to FLUSH.
  - Else (no sample ever accepted), go to IDLE without a done pulse.
- PAD: one zero step per cycle; go to FLUSH on the step that wraps ctrl_cnt to 0.
- FLUSH: exactly PIPE_LATENCY zero steps. On the last one, go to IDLE, pulse done the following cycle, and clear fill_cnt and out_cnt.
- Ignored requests: start outside IDLE; flush outside RUN.
- Flush bookkeeping: flush_cnt is $clog2(4*N_POINTS+1) bits, loads on FLUSH entry and counts down.

## Timing
- start in cycle t: busy=1 and in_ready=1 in cycle t+1. No sample can be accepted in cycle t.
- Handshake: a sample transfers on in_valid & in_ready in the same cycle. in_valid low in RUN freezes ctrl_cnt, fill_cnt and out_cnt, and drives fft_en=0.
- Output latency: the result for the k-th step (counting from 0 since the session began) is flagged by out_valid on step k+PIPE_LATENCY. Outputs are qualified at the same clock edge as that step.
- Frames are back-to-back in RUN with no bubble; ctrl_cnt wraps N_POINTS-1 -> 0.
- PAD length = N_POINTS - ctrl_cnt cycles. FLUSH length = PIPE_LATENCY cycles. Both run with fft_en=1 every cycle.
- done is asserted in the first IDLE cycle after FLUSH, for one cycle.
- Reset mid-operation: all outputs are 0 in the cycle after rst is sampled high. Pipeline contents are discarded, and the next session refills from fill_cnt=0.

## Test plan
1. Single frame. N=16, LAT=15. start, then 16 contiguous samples with flush on the 16th -> direct RUN->FLUSH with no PAD. Check:
   - out_valid on steps 15..30 (16 outputs).
   - out_index sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
   - out_first at step 15, out_last at step 30.
   - done one cycle after the 15th flush step; busy low.
2. Back-pressure. in_valid toggled 1,0,1,0 over 32 samples -> fft_en mirrors the accepted samples only; ctrl_cnt and out_cnt hold during gaps; 32 out_valid in total after flush.
3. Partial frame. flush together with the 5th sample -> ctrl_cnt=5, then PAD for 11 cycles with zero_in=1, then FLUSH for 15 cycles; exactly 16 out_valid.
4. Multi-frame. 3 back-to-back frames -> 48 out_valid, with out_last on output 15, 31 and 47; no bubble at the frame boundaries.
5. Illegal and idle requests:
   - flush in IDLE -> no state change.
   - start during RUN -> ignored.
   - start then immediate flush with no sample -> back to IDLE, no done pulse.
6. Reset mid-FLUSH (step 7 of 15) -> next cycle all outputs are 0 and the state is IDLE. A following start plus 16 samples produces its first out_valid at step 15 again.
